// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM states, frame width, minimum SCK half-period and the host byte payload.
package spi_pkg;

  localparam int unsigned SPI_BYTE_W   = 8;
  localparam int unsigned SPI_BIT_W    = $clog2(SPI_BYTE_W);
  // Matches the slave's 3-flop oversampling requirement.
  localparam int unsigned SPI_MIN_HALF = 4;
  localparam int unsigned SPI_TMR_W    = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    BOUNDARY,
    HOLD,
    GAP
  } spi_state_e;

  typedef struct packed {
    logic                  last;
    logic [SPI_BYTE_W-1:0] data;
  } spi_tx_t;

  // Timer load value giving a state dwell of exactly 'cycles' clocks.
  function automatic logic [SPI_TMR_W-1:0] tmr_reload(input int unsigned cycles);
    return SPI_TMR_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// Host-side byte stream of the SPI master: tx valid/ready handshake, rx strobe and busy.
interface spi_master_if;

  logic [spi_pkg::SPI_BYTE_W-1:0] tx_data;
  logic                           tx_valid;
  logic                           tx_last;
  logic                           tx_ready;
  logic [spi_pkg::SPI_BYTE_W-1:0] rx_data;
  logic                           rx_valid;
  logic                           busy;

  modport master (
    output tx_data, tx_valid, tx_last,
    input  tx_ready, rx_data, rx_valid, busy
  );

  modport slave (
    input  tx_data, tx_valid, tx_last,
    output tx_ready, rx_data, rx_valid, busy
  );

endinterface

// File: rtl/spi_master_timer.sv
// Loadable down-counter that saturates at zero; zero_o is registered alongside the count.
module spi_master_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         zero_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= (cnt_d == '0);
    end
  end

  assign zero_o = zero_q;

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 initiator, MSB first, 8-bit frames, fed by a valid/ready byte stream.
// Optional SPI_MASTER_LOOPBACK_EN adds a loopback input that routes MOSI into the receive path.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 8,
  parameter int unsigned CS_SETUP    = 8,
  parameter int unsigned CS_GAP      = 8
) (
  input  logic        clk,
  input  logic        rst,
  spi_master_if.slave bus,
  output logic        SCK,
  output logic        MOSI,
  output logic        SSEL,
  input  logic        MISO
`ifdef SPI_MASTER_LOOPBACK_EN
  ,
  input  logic        loopback
`endif
);

  if (HALF_PERIOD < SPI_MIN_HALF || HALF_PERIOD > 255) begin : g_bad_half
    $error("spi_master: HALF_PERIOD must be within 4..255");
  end
  if (CS_SETUP < 1 || CS_SETUP > 256 || CS_GAP < 1 || CS_GAP > 256) begin : g_bad_cs
    $error("spi_master: CS_SETUP and CS_GAP must be within 1..256");
  end

  spi_state_e            state_q, state_d;
  spi_tx_t               tx_q, tx_d;
  logic [SPI_BYTE_W-2:0] rx_shift_q, rx_shift_d;
  logic [SPI_BYTE_W-1:0] rx_data_q, rx_data_d;
  logic [SPI_BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  sck_q, sck_d, ssel_q, ssel_d, mosi_q, mosi_d;
  logic                  ready_q, ready_d, busy_q, busy_d;
  logic                  miso_meta_q, miso_sync_q, miso_src;
  logic                  hs, tmr_load, tmr_zero;
  logic [SPI_TMR_W-1:0]  tmr_val;

`ifdef SPI_MASTER_LOOPBACK_EN
  logic lb_q, lb_d;

  // Loopback mode is frozen for the whole transaction once it leaves IDLE.
  assign lb_d = (state_q == IDLE) ? loopback : lb_q;

  always_ff @(posedge clk) begin
    if (rst) lb_q <= 1'b0;
    else     lb_q <= lb_d;
  end

  assign miso_src = lb_q ? mosi_q : MISO;
`else
  assign miso_src = MISO;
`endif

  assign hs       = bus.tx_valid && ready_q;
  assign tmr_load = (state_d != state_q);

  spi_master_timer #(.W(SPI_TMR_W)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .zero_o    (tmr_zero)
  );

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    bit_cnt_d  = bit_cnt_q;
    sck_d      = sck_q;
    ssel_d     = ssel_q;
    mosi_d     = mosi_q;
    tmr_val    = '0;
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          tx_d    = '{last: bus.tx_last, data: bus.tx_data};
          mosi_d  = bus.tx_data[SPI_BYTE_W-1];
          ssel_d  = 1'b0;
          state_d = SETUP;
          tmr_val = tmr_reload(CS_SETUP);
        end
      end
      SETUP: begin
        if (tmr_zero) begin
          sck_d   = 1'b1;
          state_d = HIGH;
          tmr_val = tmr_reload(HALF_PERIOD);
        end
      end
      HIGH: begin
        if (tmr_zero) begin
          sck_d      = 1'b0;
          rx_shift_d = {rx_shift_q[SPI_BYTE_W-3:0], miso_sync_q};
          bit_cnt_d  = bit_cnt_q + SPI_BIT_W'(1);
          tmr_val    = tmr_reload(HALF_PERIOD);
          if (bit_cnt_q == SPI_BIT_W'(SPI_BYTE_W - 1)) begin
            rx_valid_d = 1'b1;
            rx_data_d  = {rx_shift_q, miso_sync_q};
            state_d    = BOUNDARY;
          end else begin
            // Rotate keeps every shift bit live; MOSI takes the next bit on the falling edge.
            tx_d.data = {tx_q.data[SPI_BYTE_W-2:0], tx_q.data[SPI_BYTE_W-1]};
            mosi_d    = tx_q.data[SPI_BYTE_W-2];
            state_d   = LOW;
          end
        end
      end
      LOW: begin
        if (tmr_zero) begin
          sck_d   = 1'b1;
          state_d = HIGH;
          tmr_val = tmr_reload(HALF_PERIOD);
        end
      end
      BOUNDARY: begin
        // Last byte: finish the final SCK low half before the hold time.
        if (tx_q.last) begin
          if (tmr_zero) begin
            state_d = HOLD;
            tmr_val = tmr_reload(CS_SETUP);
          end
        end else if (hs) begin
          tx_d    = '{last: bus.tx_last, data: bus.tx_data};
          mosi_d  = bus.tx_data[SPI_BYTE_W-1];
          state_d = LOW;
          tmr_val = tmr_reload(HALF_PERIOD);
        end
      end
      HOLD: begin
        if (tmr_zero) begin
          ssel_d  = 1'b1;
          state_d = GAP;
          tmr_val = tmr_reload(CS_GAP);
        end
      end
      GAP: begin
        if (tmr_zero) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE) || ((state_d == BOUNDARY) && !tx_d.last);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tx_q        <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      bit_cnt_q   <= '0;
      sck_q       <= 1'b0;
      ssel_q      <= 1'b1;
      mosi_q      <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      miso_meta_q <= 1'b0;
      miso_sync_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      bit_cnt_q   <= bit_cnt_d;
      sck_q       <= sck_d;
      ssel_q      <= ssel_d;
      mosi_q      <= mosi_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      miso_meta_q <= miso_src;
      miso_sync_q <= miso_meta_q;
    end
  end

  assign SCK          = sck_q;
  assign MOSI         = mosi_q;
  assign SSEL         = ssel_q;
  assign bus.tx_ready = ready_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master with a mode-0 slave model and MOSI/rx scoreboards.
module tb_spi_master;
  import spi_pkg::*;

  localparam int unsigned HP  = 8;
  localparam int unsigned CSS = 8;
  localparam int unsigned CSG = 8;
  localparam int unsigned LOW_LEN = 2 * CSS + 16 * HP;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sck, mosi, ssel;
  logic miso = 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
  logic loopback = 1'b0;
`endif

  always #5 clk = ~clk;

  spi_master_if bus();

  spi_master #(.HALF_PERIOD(HP), .CS_SETUP(CSS), .CS_GAP(CSG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .SCK (sck),
    .MOSI(mosi),
    .SSEL(ssel),
    .MISO(miso)
`ifdef SPI_MASTER_LOOPBACK_EN
    ,
    .loopback(loopback)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_mosi_q[$];
  logic [7:0] exp_rx_q[$];
  logic [7:0] resp_q[$];

  int sck_rises = 0, ssel_falls = 0, rx_count = 0;
  int low_cnt = 0, high_cnt = 0, last_low_len = 0, last_gap_len = 0;
  logic prev_ssel = 1'b1;

  logic [7:0] s_tx = 8'h00, s_rx = 8'h00;
  int s_rise = 0, s_fall = 0;
  logic s_loaded = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Slave model: next response byte loads on SSEL fall or after the 8th falling edge.
  always @(negedge ssel) begin
    ssel_falls++;
    s_rise = 0;
    s_fall = 0;
    if (!s_loaded) s_tx = (resp_q.size() != 0) ? resp_q.pop_front() : 8'h00;
    s_loaded = 1'b0;
    miso = s_tx[7];
  end

  always @(posedge ssel) begin
    s_rise = 0;
    s_fall = 0;
  end

  always @(negedge sck) begin
    if (ssel === 1'b0) begin
      s_fall++;
      if (s_fall == 8) begin
        s_fall   = 0;
        s_loaded = (resp_q.size() != 0);
        s_tx     = s_loaded ? resp_q.pop_front() : 8'h00;
      end else begin
        s_tx = {s_tx[6:0], 1'b0};
      end
      miso = s_tx[7];
    end
  end

  always @(posedge sck) begin
    logic [7:0] e;
    sck_rises++;
    if (ssel === 1'b0) begin
      chk("mosi_expected", 32'(exp_mosi_q.size() != 0), 32'd1);
      if (exp_mosi_q.size() != 0) begin
        e = exp_mosi_q[0];
        chk("mosi_bit", mosi, e[7 - s_rise]);
        s_rx = {s_rx[6:0], mosi};
        s_rise++;
        if (s_rise == 8) begin
          s_rise = 0;
          chk("mosi_byte", s_rx, exp_mosi_q.pop_front());
        end
      end
    end
  end

  // Receive scoreboard and SSEL low/high interval tracking.
  always @(negedge clk) begin
    if (!rst && bus.rx_valid === 1'b1) begin
      rx_count++;
      chk("rx_expected", 32'(exp_rx_q.size() != 0), 32'd1);
      if (exp_rx_q.size() != 0) chk("rx_data", bus.rx_data, exp_rx_q.pop_front());
    end
    if (prev_ssel === 1'b0 && ssel === 1'b1) begin
      last_low_len = low_cnt;
      high_cnt     = 1;
    end else if (prev_ssel === 1'b1 && ssel === 1'b0) begin
      last_gap_len = high_cnt;
      low_cnt      = 1;
    end else if (ssel === 1'b0) begin
      low_cnt++;
    end else begin
      high_cnt++;
    end
    prev_ssel = ssel;
  end

  task automatic send(input logic [7:0] d, input logic last, input logic [7:0] exp_rx);
    logic acc;
    acc = 1'b0;
    exp_rx_q.push_back(exp_rx);
    exp_mosi_q.push_back(d);
    bus.tx_data  = d;
    bus.tx_last  = last;
    bus.tx_valid = 1'b1;
    for (int i = 0; i < 4000 && !acc; i++) begin
      if (bus.tx_ready === 1'b1) begin
        @(posedge clk);
        acc = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    @(negedge clk);
    bus.tx_valid = 1'b0;
    bus.tx_last  = 1'b0;
    bus.tx_data  = 8'h00;
    chk("handshake", 32'(acc), 32'd1);
  endtask

  task automatic wait_done();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 4000 && !done; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b0 && exp_rx_q.size() == 0) done = 1'b1;
    end
    chk("txn_complete", 32'(done), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base_r, base_f, base_rx, bad;
    logic ok;
    bus.tx_valid = 1'b0;
    bus.tx_last  = 1'b0;
    bus.tx_data  = 8'h00;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sck", sck, 1'b0);
    chk("rst_ssel", ssel, 1'b1);
    chk("rst_mosi", mosi, 1'b0);
    chk("rst_tx_ready", bus.tx_ready, 1'b0);
    chk("rst_rx_valid", bus.rx_valid, 1'b0);
    chk("rst_rx_data", bus.rx_data, 8'h00);
    chk("rst_busy", bus.busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_tx_ready", bus.tx_ready, 1'b1);

    // Single byte 0xA5 against slave response 0x3C.
    base_r = sck_rises; base_rx = rx_count;
    resp_q.push_back(8'h3C);
    send(8'hA5, 1'b1, 8'h3C);
    wait_done();
    chk("single_rx_pulses", 32'(rx_count - base_rx), 32'd1);
    chk("single_rises", 32'(sck_rises - base_r), 32'd8);
    chk_rng("single_ssel_low", last_low_len, LOW_LEN - 1, LOW_LEN + 1);

    // Burst of three bytes within one select.
    base_r = sck_rises; base_f = ssel_falls; base_rx = rx_count;
    resp_q.push_back(8'h11); resp_q.push_back(8'h22); resp_q.push_back(8'h33);
    send(8'h01, 1'b0, 8'h11);
    send(8'h02, 1'b0, 8'h22);
    send(8'hFF, 1'b1, 8'h33);
    wait_done();
    chk("burst_rises", 32'(sck_rises - base_r), 32'd24);
    chk("burst_ssel_falls", 32'(ssel_falls - base_f), 32'd1);
    chk("burst_rx_pulses", 32'(rx_count - base_rx), 32'd3);

    // Stall at the byte boundary for 50 cycles.
    resp_q.push_back(8'h44); resp_q.push_back(8'h55);
    base_rx = rx_count;
    send(8'h81, 1'b0, 8'h44);
    ok = 1'b0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge clk);
      if (rx_count != base_rx) ok = 1'b1;
    end
    chk("stall_reached", 32'(ok), 32'd1);
    base_r = sck_rises; bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sck !== 1'b0 || ssel !== 1'b0) bad++;
    end
    chk("stall_lines", 32'(bad), 32'd0);
    chk("stall_rises", 32'(sck_rises - base_r), 32'd0);
    chk("stall_tx_ready", bus.tx_ready, 1'b1);
    send(8'h5A, 1'b1, 8'h55);
    wait_done();
    chk("stall_resume_rises", 32'(sck_rises - base_r), 32'd8);

    // Reset after the third SCK rise of a byte.
    resp_q.push_back(8'h99);
    base_rx = rx_count;
    send(8'hE7, 1'b1, 8'h99);
    base_r = sck_rises; ok = 1'b0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge clk);
      if (sck_rises - base_r >= 3) ok = 1'b1;
    end
    chk("rst_mid_reached", 32'(ok), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_ssel", ssel, 1'b1);
    chk("rst_mid_sck", sck, 1'b0);
    chk("rst_mid_rx_valid", bus.rx_valid, 1'b0);
    exp_mosi_q.delete(); exp_rx_q.delete(); resp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_no_rx", 32'(rx_count - base_rx), 32'd0);
    resp_q.push_back(8'h5C);
    send(8'hC3, 1'b1, 8'h5C);
    wait_done();
    chk("post_rst_rx_pulses", 32'(rx_count - base_rx), 32'd1);

    // Two single-byte transactions back to back; busy and SSEL held across the gap.
    resp_q.push_back(8'h21); resp_q.push_back(8'h43);
    base_f = ssel_falls;
    send(8'h12, 1'b1, 8'h21);
    fork
      send(8'h34, 1'b1, 8'h43);
      begin
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 4000 && !seen; i++) begin
          @(negedge clk);
          if (ssel === 1'b1) seen = 1'b1;
        end
        chk("gap_seen", 32'(seen), 32'd1);
        for (int i = 0; i < int'(CSG); i++) begin
          chk("gap_busy", bus.busy, 1'b1);
          chk("gap_ssel", ssel, 1'b1);
          @(negedge clk);
        end
      end
    join
    wait_done();
    chk("b2b_ssel_falls", 32'(ssel_falls - base_f), 32'd2);
    chk_rng("b2b_gap_len", last_gap_len, CSG, CSG + 16);

`ifdef SPI_MASTER_LOOPBACK_EN
    // Loopback: rx follows MOSI, not the MISO pin.
    loopback = 1'b1;
    resp_q.push_back(8'h69);
    send(8'h96, 1'b1, 8'h96);
    wait_done();
    loopback = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
